serial_subtractor: RTL

//   Bit-serial unsigned subtractor computing diff = a - b, LSB first, one bit per clock.

---
 rtl/serial_subtractor.sv | 111 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor (diff = a - b), LSB first, one bit per clock
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   in_valid   operands a/b valid
//   in_ready   high only while idle; operands accepted on in_valid && in_ready
//   a, b       minuend / subtrahend, captured at the input handshake
//   out_valid  diff/bout (and ovf) hold a completed result
//   out_ready  consumer accepts the result
//   diff       (a - b) mod 2**WIDTH
//   bout       final borrow, 1 iff a < b (unsigned)
//   ovf        two's complement overflow, present only when SERIAL_SUB_OVF_EN is defined
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the ovf port and its capture logic.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d, borrow_nxt, last;

    // one full-subtractor cell on the current LSBs
    assign d          = a_sr[0] ^ b_sr[0] ^ borrow;
    assign borrow_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
    assign last       = cnt == CW'(WIDTH - 1);

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign diff      = diff_sr;
    assign bout      = borrow;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = in_valid  ? RUN  : IDLE;
            RUN:     state_nxt = last      ? DONE : RUN;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
        end else if (state == IDLE && in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            // result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts
            diff_sr <= WIDTH'({d, diff_sr} >> 1);
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            borrow  <= borrow_nxt;
            cnt     <= cnt + CW'(1);
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb, b_msb;

    // the last RUN cell produces the result MSB, so ovf is decided on that edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == RUN && last) begin
            ovf <= (a_msb != b_msb) && (d != a_msb);
        end
    end
`endif

endmodule
